// File: rtl/ascon_fsm.sv
// Control sequencer for the ASCON-128 permutation datapath: INIT, AD, PT, FINAL.
// Optional build macro ASCON_AD_SKIP_EN adds no_ad_i for the empty-associated-data mode.
module ascon_fsm #(
    parameter int NB_ROUNDS_A = 12,
    parameter int NB_ROUNDS_B = 6
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    input  logic       last_block_i,
`ifdef ASCON_AD_SKIP_EN
    input  logic       no_ad_i,
`endif
    output logic [3:0] round_o,
    output logic       data_sel_o,
    output logic       en_reg_state_o,
    output logic       en_xor_data_o,
    output logic       en_xor_key_o,
    output logic       en_xor_key_end_o,
    output logic       en_xor_lsb_o,
    output logic       en_cipher_o,
    output logic       en_tag_o,
    output logic       data_ready_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [2:0] {
        IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE
    } state_t;

    // Every permutation ends on round 11; p^a and p^b differ only in the first index.
    localparam logic [3:0] RND_A_FIRST = 4'(12 - NB_ROUNDS_A);
    localparam logic [3:0] RND_B_FIRST = 4'(12 - NB_ROUNDS_B);
    localparam logic [3:0] RND_LAST    = 4'd11;

    state_t     state, state_d;
    logic [3:0] rnd, rnd_d;
    logic       last_q, last_d;

`ifdef ASCON_AD_SKIP_EN
    logic no_ad_q, no_ad_d;
`else
    localparam logic no_ad_q = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state  <= IDLE;
            rnd    <= '0;
            last_q <= 1'b0;
        end else begin
            state  <= state_d;
            rnd    <= rnd_d;
            last_q <= last_d;
        end
    end

`ifdef ASCON_AD_SKIP_EN
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) no_ad_q <= 1'b0;
        else         no_ad_q <= no_ad_d;
    end
`endif

    assign round_o = rnd;

    // NOTE: every variable driven here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d          = state;
        rnd_d            = rnd;
        last_d           = last_q;
`ifdef ASCON_AD_SKIP_EN
        no_ad_d          = no_ad_q;
`endif
        data_sel_o       = 1'b0;
        en_reg_state_o   = 1'b0;
        en_xor_data_o    = 1'b0;
        en_xor_key_o     = 1'b0;
        en_xor_key_end_o = 1'b0;
        en_xor_lsb_o     = 1'b0;
        en_cipher_o      = 1'b0;
        en_tag_o         = 1'b0;
        data_ready_o     = 1'b0;
        busy_o           = 1'b0;
        done_o           = 1'b0;

        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_d = INIT;
                    rnd_d   = RND_A_FIRST;
`ifdef ASCON_AD_SKIP_EN
                    no_ad_d = no_ad_i;
`endif
                end
            end

            INIT: begin
                busy_o         = 1'b1;
                en_reg_state_o = 1'b1;
                // First round loads the IV/key/nonce state; later rounds feed back.
                data_sel_o     = (rnd != RND_A_FIRST);
                if (rnd == RND_LAST) begin
                    en_xor_key_end_o = 1'b1;
                    en_xor_lsb_o     = no_ad_q;
                    state_d          = no_ad_q ? WAIT_PT : WAIT_AD;
                end else begin
                    rnd_d = rnd + 4'd1;
                end
            end

            WAIT_AD: begin
                busy_o       = 1'b1;
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    last_d  = last_block_i;
                    state_d = AD;
                    rnd_d   = RND_B_FIRST;
                end
            end

            AD: begin
                busy_o         = 1'b1;
                en_reg_state_o = 1'b1;
                data_sel_o     = 1'b1;
                en_xor_data_o  = (rnd == RND_B_FIRST);
                if (rnd == RND_LAST) begin
                    en_xor_lsb_o = last_q;
                    state_d      = last_q ? WAIT_PT : WAIT_AD;
                end else begin
                    rnd_d = rnd + 4'd1;
                end
            end

            WAIT_PT: begin
                busy_o       = 1'b1;
                data_ready_o = 1'b1;
                if (data_valid_i) begin
                    last_d = last_block_i;
                    // The last plaintext block is absorbed by the first FINAL round.
                    if (last_block_i) begin
                        state_d = FINAL;
                        rnd_d   = RND_A_FIRST;
                    end else begin
                        state_d = PT;
                        rnd_d   = RND_B_FIRST;
                    end
                end
            end

            PT: begin
                busy_o         = 1'b1;
                en_reg_state_o = 1'b1;
                data_sel_o     = 1'b1;
                en_xor_data_o  = (rnd == RND_B_FIRST);
                en_cipher_o    = (rnd == RND_B_FIRST);
                if (rnd == RND_LAST) state_d = WAIT_PT;
                else                 rnd_d   = rnd + 4'd1;
            end

            FINAL: begin
                busy_o         = 1'b1;
                en_reg_state_o = 1'b1;
                data_sel_o     = 1'b1;
                if (rnd == RND_A_FIRST) begin
                    en_xor_data_o = 1'b1;
                    en_cipher_o   = 1'b1;
                    en_xor_key_o  = 1'b1;
                end
                if (rnd == RND_LAST) begin
                    en_xor_key_end_o = 1'b1;
                    en_tag_o         = 1'b1;
                    state_d          = DONE;
                    rnd_d            = '0;
                end else begin
                    rnd_d = rnd + 4'd1;
                end
            end

            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ascon_fsm.sv
// Directed bench for ascon_fsm: records one output word per cycle after start
// and compares it against hand-derived schedules.
module tb_ascon_fsm;

    logic       clock_i = 1'b0;
    logic       reset_i, start_i, data_valid_i, last_block_i;
`ifdef ASCON_AD_SKIP_EN
    logic       no_ad_i;
`endif
    logic [3:0] round_o;
    logic       data_sel_o, en_reg_state_o, en_xor_data_o, en_xor_key_o;
    logic       en_xor_key_end_o, en_xor_lsb_o, en_cipher_o, en_tag_o;
    logic       data_ready_o, busy_o, done_o;

    int n_vec = 0;
    int n_err = 0;

    // Output word: {round[3:0], sel, reg, xdata, xkey, kend, lsb, cipher, tag, ready, busy, done}
    logic [14:0] tr [0:127];
    int          done_cyc;

    ascon_fsm dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .start_i          (start_i),
        .data_valid_i     (data_valid_i),
        .last_block_i     (last_block_i),
`ifdef ASCON_AD_SKIP_EN
        .no_ad_i          (no_ad_i),
`endif
        .round_o          (round_o),
        .data_sel_o       (data_sel_o),
        .en_reg_state_o   (en_reg_state_o),
        .en_xor_data_o    (en_xor_data_o),
        .en_xor_key_o     (en_xor_key_o),
        .en_xor_key_end_o (en_xor_key_end_o),
        .en_xor_lsb_o     (en_xor_lsb_o),
        .en_cipher_o      (en_cipher_o),
        .en_tag_o         (en_tag_o),
        .data_ready_o     (data_ready_o),
        .busy_o           (busy_o),
        .done_o           (done_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic logic [14:0] pack_out();
        return {round_o, data_sel_o, en_reg_state_o, en_xor_data_o, en_xor_key_o,
                en_xor_key_end_o, en_xor_lsb_o, en_cipher_o, en_tag_o,
                data_ready_o, busy_o, done_o};
    endfunction

    // Schedule for 1 AD block (last), PT block 2, PT block 3 (last), no stalls.
    function automatic void exp_base(input int c, output logic [14:0] e, output logic [14:0] m);
        logic [3:0] r;
        logic sel, rg, xd, xk, ke, ls, ci, tg, rd, bz, dn;
        r = '0; sel = 0; rg = 0; xd = 0; xk = 0; ke = 0; ls = 0; ci = 0; tg = 0;
        rd = 0; bz = 0; dn = 0;
        m = '1;
        if (c >= 1 && c <= 12) begin
            r = 4'(c - 1); sel = (c > 1); rg = 1; ke = (c == 12); bz = 1;
        end else if (c == 13 || c == 20 || c == 27) begin
            r = 4'd11; rd = 1; bz = 1; m[10] = 1'b0;
        end else if (c >= 14 && c <= 19) begin
            r = 4'(c - 8); sel = 1; rg = 1; bz = 1; xd = (c == 14); ls = (c == 19);
        end else if (c >= 21 && c <= 26) begin
            r = 4'(c - 15); sel = 1; rg = 1; bz = 1; xd = (c == 21); ci = (c == 21);
        end else if (c >= 28 && c <= 39) begin
            r = 4'(c - 28); sel = 1; rg = 1; bz = 1;
            xd = (c == 28); ci = (c == 28); xk = (c == 28);
            ke = (c == 39); tg = (c == 39);
        end else if (c == 40) begin
            dn = 1; m[14:11] = 4'h0;
        end
        e = {r, sel, rg, xd, xk, ke, ls, ci, tg, rd, bz, dn};
    endfunction

    // Runs one encryption from IDLE. Block k carries last_tbl[k]; block stall_blk
    // is withheld for stall_len wait cycles; poke raises start_i during cycles 14..19.
    task automatic run_txn(input logic [7:0] last_tbl, input int stall_blk,
                           input int stall_len, input bit poke);
        int c, blk, stalled;
        c = 0; blk = 0; stalled = 0; done_cyc = -1;
        for (int i = 0; i < 128; i++) tr[i] = '0;
        @(negedge clock_i);
        start_i = 1'b1; data_valid_i = 1'b0; last_block_i = 1'b0;
        @(posedge clock_i); #1;
        start_i = 1'b0;
        c = 1;
        tr[1] = pack_out();
        while (c < 120 && done_cyc < 0) begin
            start_i      = poke && (c >= 14 && c <= 19);
            data_valid_i = 1'b1;
            last_block_i = (blk < 8) ? last_tbl[blk] : 1'b1;
            if (data_ready_o && blk == stall_blk && stalled < stall_len) begin
                data_valid_i = 1'b0;
                stalled++;
            end
            if (data_ready_o && data_valid_i) blk++;
            @(posedge clock_i); #1;
            c++;
            tr[c] = pack_out();
            if (done_o) done_cyc = c;
        end
        start_i = 1'b0; data_valid_i = 1'b0; last_block_i = 1'b0;
        @(posedge clock_i); #1;
        tr[c + 1] = pack_out();
        if (done_cyc < 0) begin
            n_vec++; n_err++;
            $display("FAIL txn_timeout: no done_o within %0d cycles", c);
        end
    endtask

    task automatic check_word(input string name, input int c, input logic [14:0] e,
                              input logic [14:0] m);
        n_vec++;
        if ((tr[c] & m) !== (e & m)) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h (mask %h)", name, c, tr[c], e, m);
        end
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        reset_i = 1'b1; start_i = 1'b0; data_valid_i = 1'b0; last_block_i = 1'b0;
        repeat (2) @(posedge clock_i);
        #1;
        obs = pack_out();
        n_vec++;
        if (obs !== 15'h0) begin
            n_err++; $display("FAIL reset_state: got %h expected %h", obs, 15'h0);
        end
        @(negedge clock_i) reset_i = 1'b0;
        data_valid_i = 1'b1; last_block_i = 1'b1;
        repeat (3) @(posedge clock_i);
        #1;
        obs = pack_out();
        n_vec++;
        if (obs !== 15'h0) begin
            n_err++; $display("FAIL idle_ignores_valid: got %h expected %h", obs, 15'h0);
        end
        data_valid_i = 1'b0; last_block_i = 1'b0;
        @(negedge clock_i) start_i = 1'b1;
        @(posedge clock_i); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clock_i);
        #1;
        n_vec++;
        if (round_o !== 4'd5 || busy_o !== 1'b1) begin
            n_err++; $display("FAIL mid_init_round: got round %0d busy %b expected 5 1", round_o, busy_o);
        end
        #2 reset_i = 1'b1;
        #1;
        obs = pack_out();
        n_vec++;
        if (obs !== 15'h0) begin
            n_err++; $display("FAIL reset_async: got %h expected %h", obs, 15'h0);
        end
        @(negedge clock_i) reset_i = 1'b0;
        @(negedge clock_i) start_i = 1'b1;
        @(posedge clock_i); #1;
        start_i = 1'b0;
        obs = pack_out();
        n_vec++;
        if (obs !== {4'd0, 2'b01, 6'b0, 3'b010}) begin
            n_err++; $display("FAIL restart_round0: got %h expected %h", obs, {4'd0, 2'b01, 6'b0, 3'b010});
        end
        @(posedge clock_i); #1;
        obs = pack_out();
        n_vec++;
        if (obs !== {4'd1, 2'b11, 6'b0, 3'b010}) begin
            n_err++; $display("FAIL restart_round1: got %h expected %h", obs, {4'd1, 2'b11, 6'b0, 3'b010});
        end
        @(negedge clock_i) reset_i = 1'b1;
        @(negedge clock_i) reset_i = 1'b0;
    endtask

    task automatic test_full_sequence();
        logic [14:0] e, m;
        run_txn(8'b0000_0101, -1, 0, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            exp_base(c, e, m);
            check_word("base_seq", c, e, m);
        end
        n_vec++;
        if (done_cyc !== 40) begin
            n_err++; $display("FAIL base_latency: got %0d expected 40", done_cyc);
        end
        check_word("base_idle_after", 41, 15'h0, '1);
    endtask

    task automatic test_stall();
        run_txn(8'b0000_0101, 2, 5, 1'b0);
        for (int c = 27; c <= 32; c++)
            check_word("stall_wait", c, {4'd11, 2'b00, 6'b0, 3'b110}, 15'h7bff);
        check_word("stall_final_r0", 33, {4'd0, 2'b11, 6'b110010, 3'b010}, '1);
        check_word("stall_final_r11", 44, {4'd11, 2'b11, 6'b001001, 3'b010}, '1);
        n_vec++;
        if (done_cyc !== 45) begin
            n_err++; $display("FAIL stall_latency: got %0d expected 45", done_cyc);
        end
    endtask

    task automatic test_ignored_inputs();
        logic [14:0] e, m;
        run_txn(8'b0000_0101, -1, 0, 1'b1);
        for (int c = 14; c <= 27; c++) begin
            exp_base(c, e, m);
            check_word("ignored_seq", c, e, m);
        end
        n_vec++;
        if (done_cyc !== 40) begin
            n_err++; $display("FAIL ignored_latency: got %0d expected 40", done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        // Two AD blocks (last on the second), then one PT block that is also last.
        run_txn(8'b0000_0110, -1, 0, 1'b0);
        check_word("multi_ad_r11_nolsb", 19, {4'd11, 2'b11, 6'b000000, 3'b010}, '1);
        check_word("multi_ad_wait_ad", 20, {4'd11, 2'b00, 6'b0, 3'b110}, 15'h7bff);
        check_word("multi_ad_second_r6", 21, {4'd6, 2'b11, 6'b100000, 3'b010}, '1);
        check_word("multi_ad_lsb", 26, {4'd11, 2'b11, 6'b000100, 3'b010}, '1);
        n_vec++;
        if (done_cyc !== 40) begin
            n_err++; $display("FAIL multi_ad_latency: got %0d expected 40", done_cyc);
        end
        run_txn(8'b0000_0101, -1, 0, 1'b0);
        n_vec++;
        if (done_cyc !== 40) begin
            n_err++; $display("FAIL back_to_back_latency: got %0d expected 40", done_cyc);
        end
        check_word("back_to_back_init0", 1, {4'd0, 2'b01, 6'b0, 3'b010}, '1);
    endtask

`ifdef ASCON_AD_SKIP_EN
    task automatic test_no_ad();
        no_ad_i = 1'b1;
        run_txn(8'b0000_0010, -1, 0, 1'b0);
        no_ad_i = 1'b0;
        check_word("no_ad_init_r11", 12, {4'd11, 2'b11, 6'b001100, 3'b010}, '1);
        check_word("no_ad_wait_pt", 13, {4'd11, 2'b00, 6'b0, 3'b110}, 15'h7bff);
        check_word("no_ad_pt_r6", 14, {4'd6, 2'b11, 6'b100010, 3'b010}, '1);
        check_word("no_ad_final_r0", 21, {4'd0, 2'b11, 6'b110010, 3'b010}, '1);
        n_vec++;
        if (done_cyc !== 33) begin
            n_err++; $display("FAIL no_ad_latency: got %0d expected 33", done_cyc);
        end
    endtask
`endif

    initial begin
        reset_i = 1'b1; start_i = 1'b0; data_valid_i = 1'b0; last_block_i = 1'b0;
`ifdef ASCON_AD_SKIP_EN
        no_ad_i = 1'b0;
`endif
        test_reset();
        test_full_sequence();
        test_stall();
        test_ignored_inputs();
        test_back_to_back();
`ifdef ASCON_AD_SKIP_EN
        test_no_ad();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
